// File: rtl/hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl
//
// Multi-digit seven-segment controller for common-anode HEX displays. A value
// captured on a load strobe is shown as hex glyphs. Three display modes are
// available: static, a scrolling window for values wider than the display, and
// blink. Leading-zero blanking is optional. The segment outputs are always
// registered.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   load         single-cycle strobe that captures data_in
//   data_in      value to display (DATA_W bits, NIB = DATA_W/4 nibbles)
//   mode         00 static, 01 scroll, 10 blink, 11 treated as static
//   lz_blank     blank leading-zero digits (static/blink only)
//   enable       0 blanks every digit and freezes the counters
//   segments_out digit i at [7i+6:7i], gfedcba, active-low
// ---------------------------------------------------------------------------
module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int DATA_W     = 32,
    parameter int SCROLL_DIV = 12_500_000,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [DATA_W-1:0]       data_in,
    input  logic [1:0]              mode,
    input  logic                    lz_blank,
    input  logic                    enable,
    output logic [NUM_DIGITS*7-1:0] segments_out
);

    localparam int NIB   = DATA_W / 4;
    localparam int OFF_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int SC_W  = $clog2(SCROLL_DIV);
    localparam int BC_W  = $clog2(BLINK_DIV);

    localparam logic [1:0] MODE_SCROLL = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;

    logic [DATA_W-1:0]       held;
    logic [1:0]              prev_mode;
    logic [OFF_W-1:0]        offset;
    logic [SC_W-1:0]         scroll_cnt;
    logic [BC_W-1:0]         blink_cnt;
    logic                    phase_on;
    logic                    scroll_tick;
    logic                    blink_tick;
    logic                    restart;
    logic [NUM_DIGITS*7-1:0] next_segments;
    int                      top_digit;
    int                      src;
    logic [3:0]              nib_val;
    logic                    nib_hit;
    logic                    show;

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    assign scroll_tick = (scroll_cnt == SC_W'(SCROLL_DIV - 1));
    assign blink_tick  = (blink_cnt == BC_W'(BLINK_DIV - 1));
    // A load or any change of mode restarts the window, phase and both dividers.
    assign restart     = load || (mode != prev_mode);

    // Held value, scroll/blink timing state and the registered segment outputs.
    // Restart takes precedence over ticks, so a load on a tick edge never
    // advances the offset or toggles the phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            held         <= '0;
            prev_mode    <= mode;
            offset       <= '0;
            scroll_cnt   <= '0;
            blink_cnt    <= '0;
            phase_on     <= 1'b1;
            segments_out <= '1;
        end else begin
            prev_mode    <= mode;
            segments_out <= next_segments;
            if (load) begin
                held <= data_in;
            end
            if (restart) begin
                offset     <= '0;
                scroll_cnt <= '0;
                blink_cnt  <= '0;
                phase_on   <= 1'b1;
            end else if (enable) begin
                if (mode == MODE_SCROLL) begin
                    if (scroll_tick) begin
                        scroll_cnt <= '0;
                        offset     <= (offset == OFF_W'(NIB - 1)) ? '0 : offset + OFF_W'(1);
                    end else begin
                        scroll_cnt <= scroll_cnt + SC_W'(1);
                    end
                end else if (mode == MODE_BLINK) begin
                    if (blink_tick) begin
                        blink_cnt <= '0;
                        phase_on  <= ~phase_on;
                    end else begin
                        blink_cnt <= blink_cnt + BC_W'(1);
                    end
                end
            end
        end
    end

    // Next segment pattern. Each digit picks a source nibble (rotated by the
    // offset only when scrolling a value wider than the display); a digit whose
    // source lies beyond the value is blank. Leading-zero blanking keeps digit 0
    // and everything up to the highest nonzero displayed nibble.
    always_comb begin
        next_segments = '1;
        top_digit     = 0;
        src           = 0;
        nib_val       = 4'h0;
        nib_hit       = 1'b0;
        show          = 1'b0;
        for (int n = 0; n < NIB; n++) begin
            if (n < NUM_DIGITS && held[n*4 +: 4] != 4'h0) begin
                top_digit = n;
            end
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            src = i;
            if (mode == MODE_SCROLL && NIB > NUM_DIGITS) begin
                src = i + int'(offset);
                if (src >= NIB) begin
                    src = src - NIB;
                end
            end
            nib_val = 4'h0;
            nib_hit = 1'b0;
            for (int n = 0; n < NIB; n++) begin
                if (n == src) begin
                    nib_val = held[n*4 +: 4];
                    nib_hit = 1'b1;
                end
            end
            show = enable && nib_hit;
            if (mode == MODE_BLINK && !phase_on) begin
                show = 1'b0;
            end
            if (lz_blank && mode != MODE_SCROLL && i > top_digit) begin
                show = 1'b0;
            end
            if (show) begin
                next_segments[i*7 +: 7] = glyph(nib_val);
            end
        end
    end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
Parametrised multi-digit seven-segment display controller for the board's common-anode HEX displays. It latches a DATA_W-bit value on a load strobe and drives NUM_DIGITS registered, active-low segment fields. Modes: static, scrolling window for values wider than the display, and blink. Optional leading-zero blanking. It sits between the datapath debug taps (register or bus values) and the HEX pins.

Parameters:
NUM_DIGITS, 6, number of 7-segment digits driven (>=1)
DATA_W, 32, width of displayed value; must be a multiple of 4 and >=4; NIB = DATA_W/4
SCROLL_DIV, 12_500_000, clock cycles per scroll step (>=2)
BLINK_DIV, 25_000_000, clock cycles per blink half-period (>=2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
load  input  1  single-cycle strobe; captures data_in
data_in  input  DATA_W  value to display
mode  input  2  00 static, 01 scroll, 10 blink, 11 reserved (treated as static)
lz_blank  input  1  1 = blank leading-zero digits (static/blink modes only)
enable  input  1  0 = all digits blank, counters frozen
segments_out  output  NUM_DIGITS*7  digit i at bits [7i+6:7i], order gfedcba, active-low

Behaviour:
- Glyph encoding (active-low gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110; blank=1111111.
- Reset (rst=1 at edge): held value=0, scroll offset=0, blink phase=ON, both divider counters=0, segments_out=all 1s. After rst deasserts, the next edge drives normal output (digit 0 shows "0" in static mode).
- Latency: load sampled at edge k updates the held value. segments_out reflects it after edge k+1. segments_out is always a register, never combinational from inputs.
- Static: digit i shows nibble i of held value (digit 0 = LSB). Digits with i >= NIB are blank.
- Leading-zero blanking (lz_blank=1, modes 00/10/11): let m = index of the highest nonzero nibble among displayed digits. Blank digits i>m. Digit 0 is never blanked, so value 0 shows "0".
- Scroll (mode 01):
  - If NIB <= NUM_DIGITS, behaves as static without blanking.
  - Otherwise digit i shows nibble (offset+i) mod NIB.
  - A scroll tick fires when the scroll counter reaches SCROLL_DIV-1; the counter then returns to 0 and offset = (offset+1) mod NIB.
  - lz_blank is ignored.
- Blink (mode 10): a blink tick fires when the blink counter reaches BLINK_DIV-1 and toggles the phase. Phase OFF forces all digits blank; phase ON shows static content.
- Counters run only in their own mode with enable=1; otherwise they hold their value.
- Mode change (any edge where mode differs from the previous cycle's mode): offset=0, phase=ON, both counters=0.
- Load: offset=0, phase=ON, both counters=0, in all modes.
- Load coincident with a scroll or blink tick: load wins; no increment or toggle that cycle.
- Load coincident with a mode change: both apply, giving the same reset of offset, phase and counters.
- enable=0: segments_out all 1s on the next edge. Load still captures data. Counters, offset and phase are frozen.
- rst has priority over load, mode and enable. Reset mid-scroll or mid-blink returns to the reset state in one edge.

Test Plan:
- Reset then static, NUM_DIGITS=6, DATA_W=24: assert rst 2 cycles; segments_out=42'h3FF_FFFF_FFFF during reset. Release, load 24'h12AB3F; after edge k+1, digits 0..5 = F,3,b,A,2,1 encodings.
- Leading-zero blanking: load 24'h0000A5, lz_blank=1 -> digits 2..5 blank, digit1=A, digit0=5. Load 0 -> only digit0="0" (1000000). Set lz_blank=0 -> 000000 shown.
- Scroll, DATA_W=32, NUM_DIGITS=4, SCROLL_DIV=4: load 32'h76543210, mode=01 -> shows 3210, then 4321 after 4 cycles, then 5432. After 8 steps (offset wraps 7->0) shows 3210 again. Load on the tick cycle -> offset stays 0.
- Blink, BLINK_DIV=3: load 24'h000001, mode=10 -> phase toggles every 3 cycles (ON 3, blank 3, ...). Load mid-OFF -> immediately ON and counter restarts.
- enable=0 for 5 cycles mid-scroll: output blank and offset frozen. Load 24'hFFFFFF while disabled; re-enable -> shows FFFFFF, offset 0.
- Reset mid-scroll (offset=2): assert rst 1 cycle -> output blank, held value 0. The next cycle shows "0" in static mode.
